// File: rtl/alu_op_issuer_if.sv
// rtl/alu_op_issuer_if.sv - command, alu operand/result and response channels of the alu op issuer
interface alu_op_issuer_if #(
   parameter int DATA_W = 4,
   parameter int OPN_W  = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;
   logic [OPN_W-1:0]  cmd_opn;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OPN_W-1:0]  alu_opn;
   logic [DATA_W-1:0] alu_out0;
   logic [DATA_W-1:0] alu_out1;
   logic [DATA_W-1:0] alu_status;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_out0;
   logic [DATA_W-1:0] rsp_out1;
   logic [DATA_W-1:0] rsp_status;
   logic [OPN_W-1:0]  rsp_opn;

   // master is the issuer; slave is the command source, alu and response consumer
   modport master (
      input  cmd_valid, cmd_a, cmd_b, cmd_opn,
      output cmd_ready,
      output alu_a, alu_b, alu_opn,
      input  alu_out0, alu_out1, alu_status,
      output rsp_valid, rsp_out0, rsp_out1, rsp_status, rsp_opn,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_a, cmd_b, cmd_opn,
      input  cmd_ready,
      input  alu_a, alu_b, alu_opn,
      output alu_out0, alu_out1, alu_status,
      input  rsp_valid, rsp_out0, rsp_out1, rsp_status, rsp_opn,
      output rsp_ready
   );
endinterface

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - issues one alu operation per command, waits the alu latency, returns the result
module alu_op_issuer #(
   parameter int DATA_W  = 4,
   parameter int OPN_W   = 3,
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   alu_op_issuer_if.master     bus,
   output logic                busy,
   output logic [CNT_W-1:0]    op_count
);
   localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [LAT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] alu_a_q;
   logic [DATA_W-1:0] alu_b_q;
   logic [OPN_W-1:0]  alu_opn_q;
   logic [DATA_W-1:0] rsp_out0_q;
   logic [DATA_W-1:0] rsp_out1_q;
   logic [DATA_W-1:0] rsp_status_q;
   logic [OPN_W-1:0]  rsp_opn_q;
   logic              accept;
   logic              capture;
   logic              retire;

   assign accept  = (state == IDLE) && bus.cmd_valid;
   assign capture = (state == WAIT) && (wait_cnt == '0);
   assign retire  = (state == RESP) && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_nxt = WAIT;
         WAIT:    if (wait_cnt == '0) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cmd_ready is also masked by rst so nothing is offered while reset is held
   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      busy          = 1'b0;
      case (state)
         IDLE: bus.cmd_ready = !rst;
         WAIT: busy = 1'b1;
         RESP: begin
            bus.rsp_valid = 1'b1;
            busy          = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opn_q    <= '0;
         rsp_out0_q   <= '0;
         rsp_out1_q   <= '0;
         rsp_status_q <= '0;
         rsp_opn_q    <= '0;
         op_count     <= '0;
      end else begin
         if (accept) begin
            alu_a_q   <= bus.cmd_a;
            alu_b_q   <= bus.cmd_b;
            alu_opn_q <= bus.cmd_opn;
            rsp_opn_q <= bus.cmd_opn;
            wait_cnt  <= LAT_W'(ALU_LAT);
         end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (capture) begin
            rsp_out0_q   <= bus.alu_out0;
            rsp_out1_q   <= bus.alu_out1;
            rsp_status_q <= bus.alu_status;
         end
         if (retire) op_count <= op_count + 1'b1;
      end
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_opn    = alu_opn_q;
   assign bus.rsp_out0   = rsp_out0_q;
   assign bus.rsp_out1   = rsp_out1_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_opn    = rsp_opn_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - two issuer instances (latency 1 / 8-bit count, latency 0 / 2-bit count) against a transaction model
module tb_alu_op_issuer;
   localparam int DW = 4;
   localparam int OW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          cmd_valid;
   logic [DW-1:0] cmd_a;
   logic [DW-1:0] cmd_b;
   logic [OW-1:0] cmd_opn;
   logic          rsp_ready;
   logic          busy0, busy1;
   logic [7:0]    cnt0;
   logic [1:0]    cnt1;

   alu_op_issuer_if #(.DATA_W(DW), .OPN_W(OW)) bus0 ();
   alu_op_issuer_if #(.DATA_W(DW), .OPN_W(OW)) bus1 ();

   alu_op_issuer #(.DATA_W(DW), .OPN_W(OW), .ALU_LAT(1), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .op_count(cnt0));
   alu_op_issuer #(.DATA_W(DW), .OPN_W(OW), .ALU_LAT(0), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .op_count(cnt1));

   function automatic logic [3*DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
      logic [DW-1:0] o0, o1, st;
      o0 = a + b;
      o1 = a ^ b ^ DW'(op);
      st = DW'(op) + (a & b);
      return {o0, o1, st};
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   function automatic int mod_of(input int i);
      return (i == 0) ? 256 : 4;
   endfunction

   assign bus0.cmd_valid = cmd_valid;
   assign bus0.cmd_a     = cmd_a;
   assign bus0.cmd_b     = cmd_b;
   assign bus0.cmd_opn   = cmd_opn;
   assign bus0.rsp_ready = rsp_ready;
   assign bus1.cmd_valid = cmd_valid;
   assign bus1.cmd_a     = cmd_a;
   assign bus1.cmd_b     = cmd_b;
   assign bus1.cmd_opn   = cmd_opn;
   assign bus1.rsp_ready = rsp_ready;

   // alu with one register stage for instance 0, purely combinational for instance 1
   logic [3*DW-1:0] alu0_r;
   always @(posedge clk) alu0_r <= alu_f(bus0.alu_a, bus0.alu_b, bus0.alu_opn);
   assign {bus0.alu_out0, bus0.alu_out1, bus0.alu_status} = alu0_r;
   assign {bus1.alu_out0, bus1.alu_out1, bus1.alu_status} = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_opn);

   logic [1:0]      w_rdy, w_rv, w_busy;
   logic [DW-1:0]   w_a [2];
   logic [DW-1:0]   w_b [2];
   logic [OW-1:0]   w_opn [2];
   logic [3*DW-1:0] w_rsp [2];
   logic [OW-1:0]   w_ropn [2];
   logic [7:0]      w_cnt [2];
   assign w_rdy    = {bus1.cmd_ready, bus0.cmd_ready};
   assign w_rv     = {bus1.rsp_valid, bus0.rsp_valid};
   assign w_busy   = {busy1, busy0};
   assign w_a[0]   = bus0.alu_a;
   assign w_a[1]   = bus1.alu_a;
   assign w_b[0]   = bus0.alu_b;
   assign w_b[1]   = bus1.alu_b;
   assign w_opn[0] = bus0.alu_opn;
   assign w_opn[1] = bus1.alu_opn;
   assign w_rsp[0] = {bus0.rsp_out0, bus0.rsp_out1, bus0.rsp_status};
   assign w_rsp[1] = {bus1.rsp_out0, bus1.rsp_out1, bus1.rsp_status};
   assign w_ropn[0] = bus0.rsp_opn;
   assign w_ropn[1] = bus1.rsp_opn;
   assign w_cnt[0] = cnt0;
   assign w_cnt[1] = {6'b0, cnt1};

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // transaction model: one op outstanding, visible result ALU_LAT+1 edges after accept
   bit              m_on = 1'b0;
   bit              m_pend [2];
   int              m_since [2];
   int              m_cnt [2];
   logic [DW-1:0]   m_a [2];
   logic [DW-1:0]   m_b [2];
   logic [OW-1:0]   m_opn [2];
   logic [OW-1:0]   m_ropn [2];
   logic [3*DW-1:0] m_rsp [2];
   logic [3*DW-1:0] p_res [2];

   always @(posedge clk) begin
      if (rst) m_on <= 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_pend[i] <= 1'b0;
            m_since[i] <= 0;
            m_cnt[i]  <= 0;
            m_a[i]    <= '0;
            m_b[i]    <= '0;
            m_opn[i]  <= '0;
            m_ropn[i] <= '0;
            m_rsp[i]  <= '0;
         end else if (m_pend[i] && (m_since[i] >= lat_of(i) + 1) && rsp_ready) begin
            m_pend[i] <= 1'b0;
            m_cnt[i]  <= (m_cnt[i] + 1) % mod_of(i);
         end else if (m_pend[i]) begin
            m_since[i] <= m_since[i] + 1;
            if (m_since[i] + 1 == lat_of(i) + 1) m_rsp[i] <= p_res[i];
         end else if (cmd_valid) begin
            m_pend[i]  <= 1'b1;
            m_since[i] <= 0;
            m_a[i]     <= cmd_a;
            m_b[i]     <= cmd_b;
            m_opn[i]   <= cmd_opn;
            m_ropn[i]  <= cmd_opn;
            p_res[i]   <= alu_f(cmd_a, cmd_b, cmd_opn);
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d_cmd_ready", i), int'(w_rdy[i]), int'(!m_pend[i] && !rst));
            chk($sformatf("i%0d_rsp_valid", i), int'(w_rv[i]),
                int'(m_pend[i] && (m_since[i] >= lat_of(i) + 1)));
            chk($sformatf("i%0d_busy", i), int'(w_busy[i]), int'(m_pend[i]));
            chk($sformatf("i%0d_alu_a", i), int'(w_a[i]), int'(m_a[i]));
            chk($sformatf("i%0d_alu_b", i), int'(w_b[i]), int'(m_b[i]));
            chk($sformatf("i%0d_alu_opn", i), int'(w_opn[i]), int'(m_opn[i]));
            chk($sformatf("i%0d_rsp_data", i), int'(w_rsp[i]), int'(m_rsp[i]));
            chk($sformatf("i%0d_rsp_opn", i), int'(w_ropn[i]), int'(m_ropn[i]));
            chk($sformatf("i%0d_op_count", i), int'(w_cnt[i]), m_cnt[i]);
         end
      end
   end

   // handshake timing monitor; a handshake seen at a falling edge completes on the next rising edge
   int ncyc = 0;
   int q0 [$];
   int last_lat [2];
   int acc_cyc [2];
   bit armed [2];
   int hs_cnt [2];

   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            armed[i] <= 1'b0;
         end else begin
            if (armed[i] && w_rv[i]) begin
               last_lat[i] <= ncyc - acc_cyc[i] - 1;
               armed[i]    <= 1'b0;
            end
            if (cmd_valid && w_rdy[i]) begin
               acc_cyc[i] <= ncyc;
               armed[i]   <= 1'b1;
               if (i == 0) q0.push_back(ncyc);
            end
            if (w_rv[i] && rsp_ready) hs_cnt[i] <= hs_cnt[i] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rv(input int i);
      int k;
      k = 0;
      while (!w_rv[i] && k < 20) begin
         tick();
         k++;
      end
      chk("wait_rsp_valid", int'(w_rv[i]), 1);
   endtask

   initial begin
      int k;
      int base;
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opn = '0; rsp_ready = 1'b0;

      tick(); tick();
      @(negedge clk);
      chk("rst_cmd_ready", int'(w_rdy[0]), 0);
      chk("rst_rsp_valid", int'(w_rv[0]), 0);
      chk("rst_alu_a", int'(w_a[0]), 0);
      chk("rst_alu_opn", int'(w_opn[0]), 0);
      chk("rst_op_count", int'(w_cnt[0]), 0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("release_cmd_ready", int'(w_rdy[0]), 1);

      // single op: 3 + 7
      tick(); cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd7; cmd_opn = 3'd0; rsp_ready = 1'b0;
      tick(); cmd_valid = 1'b0;
      @(negedge clk);
      chk("single_alu_a", int'(w_a[0]), 3);
      chk("single_alu_b", int'(w_b[0]), 7);
      chk("single_early_rv", int'(w_rv[0]), 0);
      tick();
      @(negedge clk);
      chk("single_rv_t1", int'(w_rv[0]), 0);
      tick();
      @(negedge clk);
      chk("single_rv_t2", int'(w_rv[0]), 1);
      chk("single_out0", int'(bus0.rsp_out0), 10);
      chk("single_out1", int'(bus0.rsp_out1), 4);
      chk("single_status", int'(bus0.rsp_status), 3);
      chk("single_rsp_opn", int'(bus0.rsp_opn), 0);
      tick(); rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      @(negedge clk);
      chk("single_count", int'(w_cnt[0]), 1);
      chk("single_out0_kept", int'(bus0.rsp_out0), 10);

      // backpressure with a new command waiting
      tick(); cmd_valid = 1'b1; cmd_a = 4'd5; cmd_b = 4'd9; cmd_opn = 3'd3;
      wait_rv(0);
      cmd_a = 4'd1; cmd_b = 4'd2; cmd_opn = 3'd6;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("bp_out0", int'(bus0.rsp_out0), 14);
         chk("bp_rsp_opn", int'(bus0.rsp_opn), 3);
         chk("bp_cmd_ready", int'(w_rdy[0]), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_after_hs", int'(w_busy[0]), 0);
      tick(); cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_new_taken", int'(w_busy[0]), 1);
      chk("bp_new_alu_a", int'(w_a[0]), 1);
      rsp_ready = 1'b1;
      repeat (4) tick();
      rsp_ready = 1'b0;

      // back-to-back with cmd_valid held
      rst = 1'b1; tick(); rst = 1'b0;
      q0.delete();
      cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd4; cmd_opn = 3'd5; rsp_ready = 1'b1;
      repeat (9) tick();
      cmd_valid = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      chk("b2b_accepts", q0.size(), 3);
      if (q0.size() >= 3) begin
         chk("b2b_gap1", q0[1] - q0[0], 4);
         chk("b2b_gap2", q0[2] - q0[1], 4);
      end
      chk("b2b_count", int'(w_cnt[0]), 3);

      // reset while waiting on the alu
      rst = 1'b1; tick(); rst = 1'b0; rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_a = 4'd2; cmd_b = 4'd2;
      tick(); cmd_valid = 1'b0; rst = 1'b1;
      tick(); rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("abort_no_rv", int'(w_rv[0]), 0);
         tick();
      end
      @(negedge clk);
      chk("abort_count", int'(w_cnt[0]), 0);
      chk("abort_idle", int'(w_busy[0]), 0);
      chk("abort_ready", int'(w_rdy[0]), 1);

      // counter wrap on the 2-bit instance and latency of both
      rst = 1'b1; tick(); rst = 1'b0;
      base = hs_cnt[1];
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      k = 0;
      while ((hs_cnt[1] - base) < 5 && k < 100) begin
         cmd_a = DW'($urandom); cmd_b = DW'($urandom); cmd_opn = OW'($urandom);
         tick();
         k++;
      end
      cmd_valid = 1'b0;
      chk("wrap_ops_done", hs_cnt[1] - base, 5);
      @(negedge clk);
      chk("wrap_count", int'(w_cnt[1]), 1);
      chk("lat_alu1", last_lat[0], 2);
      chk("lat_alu0", last_lat[1], 1);
      repeat (4) tick();

      // random traffic, occasional reset
      repeat (600) begin
         cmd_valid = ($urandom_range(0, 9) < 7);
         cmd_a     = DW'($urandom);
         cmd_b     = DW'($urandom);
         cmd_opn   = OW'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 6);
         rst       = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
